tx_frame_scheduler: RTL

//  Sequences one TX burst into the 8x sample-hold upsampler: PRE_LEN preamble samples from the

---
 rtl/tx_frame_scheduler_pkg.sv | 26 ++
 rtl/tx_frame_scheduler_if.sv | 14 +
 rtl/tx_frame_scheduler_iq_out_reg.sv | 42 ++++
 rtl/tx_frame_scheduler.sv | 137 +++++++++++++
 4 files changed

// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types for the TX burst scheduler: I/Q sample struct, FSM state encoding
// and a small constant helper used to size the burst counter.
package tx_frame_scheduler_pkg;

    localparam int SAMPLE_DW = 12;

    typedef struct packed {
        logic signed [SAMPLE_DW-1:0] i;
        logic signed [SAMPLE_DW-1:0] q;
    } iq_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_GUARD,
        S_DRAIN
    } txsch_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Valid/ready I/Q sample stream; master drives data and valid, slave drives ready.
interface tx_frame_scheduler_if
    import tx_frame_scheduler_pkg::*;
#(
    parameter int DW = SAMPLE_DW
);
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    logic                 valid;
    logic                 ready;

    modport master (output i, output q, output valid, input ready);
    modport slave  (input i, input q, input valid, output ready);
endinterface

// File: rtl/tx_frame_scheduler_iq_out_reg.sv
// Single valid/ready register stage toward the hold stage; accepts new data whenever
// it is empty or its current sample is being taken this cycle.
module iq_out_reg
    import tx_frame_scheduler_pkg::*;
#(
    parameter int DW = SAMPLE_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    output logic                 load,
    tx_frame_scheduler_if.master out
);

    logic                 valid_q;
    logic signed [DW-1:0] i_q;
    logic signed [DW-1:0] q_q;

    assign load = ~valid_q | out.ready;

    // Data only updates on a real sample so the last value holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            i_q     <= '0;
            q_q     <= '0;
        end else if (load) begin
            valid_q <= in_valid;
            if (in_valid) begin
                i_q <= in_i;
                q_q <= in_q;
            end
        end
    end

    assign out.valid = valid_q;
    assign out.i     = i_q;
    assign out.q     = q_q;

endmodule

// File: rtl/tx_frame_scheduler.sv
// Burst sequencer: preamble, then payload, then zero guard samples into the hold stage,
// granting ready only to the source that owns the current phase.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int DW        = SAMPLE_DW,
    parameter int PRE_LEN   = 32,
    parameter int GUARD_LEN = 16,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     payload_len,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun,
    tx_frame_scheduler_if.slave  pre,
    tx_frame_scheduler_if.slave  dat,
    tx_frame_scheduler_if.master out
);

    localparam int CNT_W = max3($clog2(PRE_LEN), $clog2(GUARD_LEN), LEN_W) + 1;
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);

    txsch_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 underrun_q, underrun_d;

    logic                 load;
    logic                 src_valid;
    logic signed [DW-1:0] src_i;
    logic signed [DW-1:0] src_q;
    logic [CNT_W-1:0]     pay_last;

    assign pay_last  = CNT_W'(len_q) - CNT_W'(1);
    assign pre.ready = (state_q == S_PRE) & load;
    assign dat.ready = (state_q == S_PAY) & load;
    assign busy      = (state_q != S_IDLE);
    assign underrun  = underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            underrun_q <= underrun_d;
        end
    end

    // The source mux and counter advance only when the output register can take a sample.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        underrun_d = underrun_q;
        src_valid  = 1'b0;
        src_i      = '0;
        src_q      = '0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = payload_len;
                    underrun_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_PRE;
                end
            end
            S_PRE: begin
                src_valid = pre.valid;
                src_i     = pre.i;
                src_q     = pre.q;
                if (load && pre.valid) begin
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = '0;
                        state_d = (len_q != '0) ? S_PAY : S_GUARD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PAY: begin
                src_valid = dat.valid;
                src_i     = dat.i;
                src_q     = dat.q;
                if (load) begin
                    if (!dat.valid) begin
                        underrun_d = 1'b1;
                    end else if (cnt_q == pay_last) begin
                        cnt_d   = '0;
                        state_d = S_GUARD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GUARD: begin
                src_valid = 1'b1;
                if (load) begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out.valid && out.ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    iq_out_reg #(.DW(DW)) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (src_valid),
        .in_i     (src_i),
        .in_q     (src_q),
        .load     (load),
        .out      (out)
    );

endmodule
